// File: rtl/stdp_pkg.sv
// stdp_pkg: shared defaults, weight type and controller states
package stdp_pkg;
    localparam int F_DEF = 48;
    localparam int N_DEF = 96;
    typedef logic signed [15:0] weight_t;
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_STREAM} state_t;
endpackage

// File: rtl/stdp_weight_mem_if.sv
// stdp_weight_mem_if: init control, learner port and row-stream port of the weight memory
interface stdp_weight_mem_if import stdp_pkg::*; #(
    parameter int F  = F_DEF,
    parameter int N  = N_DEF,
    parameter int AW = $clog2(F * N)
) ();
    logic                 init_start;
    weight_t              init_value;
    logic                 busy;
    logic                 w_we;
    logic [AW-1:0]        w_addr;
    weight_t              w_wdata;
    weight_t              w_rdata;
    logic                 rd_req;
    logic [$clog2(F)-1:0] rd_f;
    logic                 rd_req_ready;
    logic                 rd_valid;
    logic                 rd_ready;
    weight_t              rd_data;
    logic [$clog2(N)-1:0] rd_n;
    logic                 rd_last;
    logic                 rd_err;
    modport slave (
        input  init_start, init_value, w_we, w_addr, w_wdata, rd_req, rd_f, rd_ready,
        output busy, w_rdata, rd_req_ready, rd_valid, rd_data, rd_n, rd_last, rd_err
    );
    modport master (
        output init_start, init_value, w_we, w_addr, w_wdata, rd_req, rd_f, rd_ready,
        input  busy, w_rdata, rd_req_ready, rd_valid, rd_data, rd_n, rd_last, rd_err
    );
endinterface

// File: rtl/stdp_row_streamer.sv
// stdp_row_streamer: walks one row, holding each prefetched word until it is taken
module stdp_row_streamer import stdp_pkg::*; #(
    parameter int N  = N_DEF,
    parameter int AW = 13,
    parameter int FW = 6,
    parameter int NW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          abort_i,
    input  logic          start_i,
    input  logic [FW-1:0] f_i,
    input  logic          ready_i,
    input  weight_t       rdata_i,
    output logic [AW-1:0] raddr_o,
    output logic          valid_o,
    output logic          last_o,
    output logic          done_o,
    output logic [NW-1:0] n_o,
    output weight_t       data_o
);
    logic          valid_q, last_q;
    logic [NW-1:0] n_q;
    logic [AW-1:0] addr_q;
    weight_t       data_q;
    logic          hs, adv;

    assign hs      = valid_q && ready_i;
    assign adv     = hs && !last_q;
    assign done_o  = hs && last_q;
    assign raddr_o = start_i ? AW'(int'(f_i) * N) : addr_q + AW'(1);
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign n_o     = n_q;
    assign data_o  = data_q;

    // data_q is captured once per word, so later writes to that address never disturb it
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            n_q     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (abort_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (start_i || adv) begin
            valid_q <= 1'b1;
            n_q     <= start_i ? '0 : n_q + NW'(1);
            last_q  <= start_i ? (N == 1) : (n_q + NW'(1) == NW'(N - 1));
            addr_q  <= raddr_o;
            data_q  <= rdata_i;
        end else if (hs) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end
endmodule

// File: rtl/stdp_weight_mem.sv
// stdp_weight_mem: F*N synaptic weights with init sweep, learner port and row streaming
module stdp_weight_mem import stdp_pkg::*; #(
    parameter int      F      = F_DEF,
    parameter int      N      = N_DEF,
    parameter int      AW     = $clog2(F * N),
    parameter weight_t INIT_W = '0
) (
    input logic              clk,
    input logic              rst,
    stdp_weight_mem_if.slave bus
);
    localparam int FW    = $clog2(F);
    localparam int NW    = $clog2(N);
    localparam int DEPTH = F * N;

    weight_t       mem [DEPTH];
    state_t        state_q, state_d;
    logic [AW-1:0] sweep_q, sweep_d, raddr;
    weight_t       fill_q, fill_d, fetch;
    logic          err_q, busy, ready, lw_commit, accept, start, done;

    assign busy      = state_q == S_INIT;
    assign ready     = state_q == S_IDLE && !bus.init_start;
    assign lw_commit = bus.w_we && !busy && int'(bus.w_addr) < DEPTH;
    assign accept    = bus.rd_req && ready;
    assign start     = accept && int'(bus.rd_f) < F;
    // Stream fetch sees a learner write landing on the same address this cycle
    assign fetch     = (lw_commit && bus.w_addr == raddr) ? bus.w_wdata : mem[raddr];

    assign bus.busy         = busy;
    assign bus.rd_req_ready = ready;
    assign bus.rd_err       = err_q;
    assign bus.w_rdata      = int'(bus.w_addr) < DEPTH ? mem[bus.w_addr] : '0;

    always_comb begin
        state_d = state_q;
        sweep_d = busy ? sweep_q + AW'(1) : sweep_q;
        fill_d  = fill_q;
        if (bus.init_start) begin
            state_d = S_INIT;
            sweep_d = '0;
            fill_d  = bus.init_value;
        end else if (state_q == S_INIT) state_d = int'(sweep_q) == DEPTH - 1 ? S_IDLE : S_INIT;
        else if (state_q == S_IDLE) state_d = start ? S_STREAM : S_IDLE;
        else state_d = done ? S_IDLE : S_STREAM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            sweep_q <= '0;
            fill_q  <= INIT_W;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            fill_q  <= fill_d;
            err_q   <= accept && !start;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (busy || lw_commit)) mem[busy ? sweep_q : bus.w_addr] <= busy ? fill_q : bus.w_wdata;
    end

    stdp_row_streamer #(.N(N), .AW(AW), .FW(FW), .NW(NW)) u_streamer (
        .clk     (clk),
        .rst     (rst),
        .abort_i (bus.init_start),
        .start_i (start),
        .f_i     (bus.rd_f),
        .ready_i (bus.rd_ready),
        .rdata_i (fetch),
        .raddr_o (raddr),
        .valid_o (bus.rd_valid),
        .last_o  (bus.rd_last),
        .done_o  (done),
        .n_o     (bus.rd_n),
        .data_o  (bus.rd_data)
    );
endmodule

// File: tb/tb_stdp_weight_mem.sv
// tb_stdp_weight_mem: directed and randomized checks against an array model of the weights
module tb_stdp_weight_mem;
    import stdp_pkg::*;
    localparam int F  = 48;
    localparam int N  = 96;
    localparam int AW = $clog2(F * N);
    localparam int FW = $clog2(F);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stdp_weight_mem_if #(.F(F), .N(N)) bus ();
    stdp_weight_mem #(.F(F), .N(N), .INIT_W(16'sd5)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors = 0;
    int miscompares = 0;
    int model [F*N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int v);
        foreach (model[i]) model[i] = v;
    endtask

    task automatic rd_chk(input string tag, input int a);
        bus.w_addr = AW'(a);
        #1;
        chk(tag, bus.w_rdata, a < F * N ? model[a] : 0);
    endtask

    task automatic lwrite(input int a, input int d);
        bus.w_we = 1'b1;
        bus.w_addr = AW'(a);
        bus.w_wdata = 16'(d);
        #1;
        chk("w_rdata_prewrite", bus.w_rdata, a < F * N ? model[a] : 0);
        tick();
        bus.w_we = 1'b0;
        if (a < F * N) model[a] = d;
    endtask

    task automatic count_busy(input string tag, input int wr_at);
        int n = 0;
        while (bus.busy === 1'b1 && n < 10000) begin
            bus.w_we = (n == wr_at);
            bus.w_addr = AW'(100);
            bus.w_wdata = -16'sd300;
            n++;
            tick();
        end
        bus.w_we = 1'b0;
        chk(tag, n, F * N);
    endtask

    task automatic stream(input int f, input bit rand_ready, input bit writes, input int stop_after);
        int base = f * N;
        int n = 0;
        int cyc = 0;
        int wa = 0;
        int wd = 0;
        int d;
        bit done = 1'b0;
        bit hs;
        bus.rd_req = 1'b1;
        bus.rd_f = FW'(f);
        bus.rd_ready = 1'b0;
        #1;
        chk("rd_req_ready", bus.rd_req_ready, 1);
        tick();
        bus.rd_req = 1'b0;
        d = model[base];
        while (!done && cyc < 2000 && cyc != stop_after) begin
            bus.rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (writes) begin
                wa = base + n + int'($urandom_range(0, 1));
                if (wa >= F * N) wa = base + n;
                wd = int'($urandom_range(0, 65535)) - 32768;
                bus.w_we = 1'b1;
                bus.w_addr = AW'(wa);
                bus.w_wdata = 16'(wd);
            end
            #1;
            chk("rd_valid", bus.rd_valid, 1);
            chk("rd_n", bus.rd_n, n);
            chk("rd_last", bus.rd_last, n == N - 1);
            chk("rd_data", bus.rd_data, d);
            hs = bus.rd_ready;
            tick();
            bus.w_we = 1'b0;
            if (writes) model[wa] = wd;
            if (hs) begin
                if (n == N - 1) done = 1'b1;
                else begin
                    n++;
                    d = model[base + n];
                end
            end
            cyc++;
        end
        if (stop_after < 0) begin
            chk("stream_complete", done, 1);
            #1;
            chk("rd_valid_after_last", bus.rd_valid, 0);
            chk("rd_req_ready_after_last", bus.rd_req_ready, 1);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.init_start = 1'b0;
        bus.init_value = '0;
        bus.w_we = 1'b0;
        bus.w_addr = '0;
        bus.w_wdata = '0;
        bus.rd_req = 1'b0;
        bus.rd_f = '0;
        bus.rd_ready = 1'b0;
        repeat (3) tick();
        chk("rst_busy", bus.busy, 1);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_n", bus.rd_n, 0);
        chk("rst_rd_last", bus.rd_last, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_rd_err", bus.rd_err, 0);
        rst = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_sweep_busy", bus.busy, 1);
        rst = 1'b0;
        count_busy("busy_len_reset", 200);
        fill(5);
        rd_chk("rd_addr0", 0);
        rd_chk("rd_addr100_busy_write_dropped", 100);
        rd_chk("rd_addr_last", F * N - 1);
        rd_chk("rd_out_of_range", F * N);
        rd_chk("rd_addr_max", (1 << AW) - 1);
        for (int i = 0; i < 10; i++) rd_chk("rd_random_init", int'($urandom_range(0, F * N - 1)));

        lwrite(100, -300);
        rd_chk("rd_after_write", 100);
        lwrite(F * N + 3, 1234);
        rd_chk("rd_oor_write_dropped", F * N + 3);
        for (int i = 0; i < 12; i++) lwrite(2 * N + int'($urandom_range(0, N - 1)), int'($urandom_range(0, 65535)) - 32768);
        for (int i = 0; i < 8; i++) rd_chk("rd_random_written", 2 * N + int'($urandom_range(0, N - 1)));

        stream(2, 1'b0, 1'b0, -1);
        stream(10, 1'b1, 1'b1, -1);
        for (int i = 0; i < 8; i++) rd_chk("rd_row10_after_stream", 10 * N + int'($urandom_range(0, N - 1)));

        bus.rd_req = 1'b1;
        bus.rd_f = FW'(48);
        #1;
        chk("err_req_ready", bus.rd_req_ready, 1);
        tick();
        bus.rd_req = 1'b0;
        #1;
        chk("rd_err_pulse", bus.rd_err, 1);
        chk("rd_err_no_valid", bus.rd_valid, 0);
        tick();
        chk("rd_err_cleared", bus.rd_err, 0);
        chk("rd_err_still_no_valid", bus.rd_valid, 0);

        stream(5, 1'b0, 1'b0, 10);
        bus.init_start = 1'b1;
        bus.init_value = -16'sd7;
        #1;
        chk("init_blocks_req_ready", bus.rd_req_ready, 0);
        tick();
        bus.init_start = 1'b0;
        bus.rd_ready = 1'b0;
        chk("abort_rd_valid", bus.rd_valid, 0);
        chk("abort_rd_last", bus.rd_last, 0);
        count_busy("busy_len_init_start", -1);
        fill(-7);
        rd_chk("rd_fill0", 0);
        rd_chk("rd_fill_last", F * N - 1);
        for (int i = 0; i < 12; i++) rd_chk("rd_random_fill", int'($urandom_range(0, F * N - 1)));

        stream(7, 1'b0, 1'b0, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.rd_ready = 1'b0;
        chk("rst_mid_stream_valid", bus.rd_valid, 0);
        chk("rst_mid_stream_data", bus.rd_data, 0);
        chk("rst_mid_stream_busy", bus.busy, 1);
        count_busy("busy_len_rst_stream", -1);
        fill(5);
        for (int i = 0; i < 6; i++) rd_chk("rd_random_refill", int'($urandom_range(0, F * N - 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
